// File: rtl/stack_proc_pkg.sv
// Shared types for the stack processor: opcode and FSM encodings, instruction field layout.
package stack_proc_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_NOT  = 3'b011,
        OP_PUSH = 3'b100,
        OP_POP  = 3'b101,
        OP_JMP  = 3'b110,
        OP_JZ   = 3'b111
    } opcode_t;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_HALT,
        S_FAULT
    } state_t;

    // Opcode occupies the top OPC_W bits of the word; the operand sits at bit 0.
    localparam int unsigned OPC_W       = 3;
    localparam int unsigned OPERAND_LSB = 0;

    function automatic logic op_is_mem(input opcode_t op);
        return (op == OP_PUSH) || (op == OP_POP);
    endfunction

    // Minimum stack occupancy an opcode needs before it may execute.
    function automatic logic [1:0] op_min_sp(input opcode_t op);
        logic [1:0] r;
        case (op)
            OP_ADD, OP_SUB, OP_AND:  r = 2'd2;
            OP_NOT, OP_POP, OP_JZ:   r = 2'd1;
            default:                 r = 2'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/stack_proc_if.sv
// Memory bus between the stack processor (master) and its instruction/data memory (slave).
interface stack_proc_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/stack_proc_lifo.sv
// Operand stack: push, pop, replace-top, and pop+push (two-operand ALU result) in one cycle.
module stack_proc_lifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       replace_top,
    input  logic [DATA_W-1:0]          din,
    output logic [DATA_W-1:0]          top,
    output logic [DATA_W-1:0]          next,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [CNT_W-1:0]  r_count;
    logic [IDX_W-1:0]  w_top_idx;
    logic [IDX_W-1:0]  w_next_idx;
    logic [IDX_W-1:0]  w_push_idx;

    always_comb begin
        w_top_idx  = (r_count >= CNT_W'(1)) ? IDX_W'(r_count - CNT_W'(1)) : '0;
        w_next_idx = (r_count >= CNT_W'(2)) ? IDX_W'(r_count - CNT_W'(2)) : '0;
        w_push_idx = (r_count < DEPTH_C)    ? IDX_W'(r_count)             : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= '0;
        end else if (pop) begin
            r_count <= r_count - CNT_W'(1);
        end else if (push) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // Entries are not reset; pop+push overwrites next-to-top, which becomes the new top.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (push && pop) begin
                r_mem[w_next_idx] <= din;
            end else if (push) begin
                r_mem[w_push_idx] <= din;
            end else if (replace_top) begin
                r_mem[w_top_idx] <= din;
            end
        end
    end

    assign top   = r_mem[w_top_idx];
    assign next  = r_mem[w_next_idx];
    assign count = r_count;

endmodule

// File: rtl/stack_proc.sv
// Multi-cycle stack processor: FETCH/DECODE/EXEC|MEM over a request/ack memory bus.
module stack_proc
    import stack_proc_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    stack_proc_if.master               bus,
    output logic [ADDR_W-1:0]          pc,
    output logic [$clog2(DEPTH+1)-1:0] sp,
    output logic                       halted,
    output logic                       fault
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    state_t            r_state;
    state_t            w_next;
    logic [DATA_W-1:0] r_ir;
    logic [ADDR_W-1:0] r_pc;
    logic              r_boot;

    opcode_t           w_opcode;
    logic [ADDR_W-1:0] w_operand;
    logic [DATA_W-1:0] w_top;
    logic [DATA_W-1:0] w_nos;
    logic [CNT_W-1:0]  w_count;
    logic [DATA_W-1:0] w_alu;
    logic              w_pre_ok;
    logic              w_req;
    logic              w_acked;
    logic              w_self_jmp;

    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;
    logic              w_ir_load;
    logic              w_pc_inc;
    logic              w_pc_load;
    logic              w_push;
    logic              w_pop;
    logic              w_replace;
    logic [DATA_W-1:0] w_din;

    assign w_opcode  = opcode_t'(r_ir[DATA_W-1 -: OPC_W]);
    assign w_operand = r_ir[OPERAND_LSB +: ADDR_W];

    stack_proc_lifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_lifo (
        .clk         (clk),
        .rst         (rst),
        .push        (w_push),
        .pop         (w_pop),
        .replace_top (w_replace),
        .din         (w_din),
        .top         (w_top),
        .next        (w_nos),
        .count       (w_count)
    );

    // No request in the first cycle after reset, nor while reset is held, so a stale ack is ignored.
    assign w_req      = rst && !r_boot && (r_state == S_FETCH || r_state == S_MEM);
    assign w_acked    = w_req && bus.mem_ack;
    assign w_self_jmp = (w_operand == (r_pc - ADDR_W'(1)));
    assign w_pre_ok   = (w_count >= CNT_W'(op_min_sp(w_opcode)))
                        && !(w_opcode == OP_PUSH && w_count == DEPTH_C);

    always_comb begin
        case (w_opcode)
            OP_ADD:  w_alu = w_nos + w_top;
            OP_SUB:  w_alu = w_nos - w_top;
            OP_AND:  w_alu = w_nos & w_top;
            default: w_alu = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:  if (w_acked) w_next = S_DECODE;
            S_DECODE: begin
                if (!w_pre_ok)                w_next = S_FAULT;
                else if (op_is_mem(w_opcode)) w_next = S_MEM;
                else                          w_next = S_EXEC;
            end
            S_EXEC:   w_next = (w_opcode == OP_JMP && w_self_jmp) ? S_HALT : S_FETCH;
            S_MEM:    if (w_acked) w_next = S_FETCH;
            S_HALT:   w_next = S_HALT;
            S_FAULT:  w_next = S_FAULT;
            default:  w_next = S_FETCH;
        endcase
    end

    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_addr  = r_pc;
        w_mem_wdata = '0;
        w_ir_load   = 1'b0;
        w_pc_inc    = 1'b0;
        w_pc_load   = 1'b0;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_replace   = 1'b0;
        w_din       = '0;
        halted      = (r_state == S_HALT);
        fault       = (r_state == S_FAULT);
        case (r_state)
            S_FETCH: begin
                w_ir_load = w_acked;
                w_pc_inc  = w_acked;
            end
            S_EXEC: begin
                case (w_opcode)
                    OP_ADD, OP_SUB, OP_AND: begin
                        w_push = 1'b1;
                        w_pop  = 1'b1;
                        w_din  = w_alu;
                    end
                    OP_NOT: begin
                        w_replace = 1'b1;
                        w_din     = ~w_top;
                    end
                    OP_JMP: w_pc_load = 1'b1;
                    OP_JZ: begin
                        w_pop     = 1'b1;
                        w_pc_load = (w_top == '0);
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                w_mem_addr = w_operand;
                if (w_opcode == OP_POP) begin
                    w_mem_we    = 1'b1;
                    w_mem_wdata = w_top;
                    w_pop       = w_acked;
                end else begin
                    w_push = w_acked;
                    w_din  = bus.mem_rdata;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc   <= '0;
            r_ir   <= '0;
            r_boot <= 1'b1;
        end else begin
            r_boot <= 1'b0;
            if (w_ir_load) r_ir <= bus.mem_rdata;
            if (w_pc_load) begin
                r_pc <= w_operand;
            end else if (w_pc_inc) begin
                r_pc <= r_pc + ADDR_W'(1);
            end
        end
    end

    assign bus.mem_req   = w_req;
    assign bus.mem_we    = w_mem_we;
    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_wdata = w_mem_wdata;
    assign pc            = r_pc;
    assign sp            = w_count;

endmodule

// File: tb/tb_stack_proc.sv
// Directed bench for stack_proc: small programs against a wait-configurable memory model.
module tb_stack_proc;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] pc;
    logic [3:0]        sp;
    logic              halted;
    logic              fault;

    stack_proc_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    stack_proc #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .pc     (pc),
        .sp     (sp),
        .halted (halted),
        .fault  (fault)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] mem [32];
    int                n_checks;
    int                n_errors;
    int                wait_n;
    int                cnt;
    int                cyc;
    int                stab_err;
    int                rd_cnt;
    logic              pend;
    logic              p_we;
    logic [ADDR_W-1:0] p_addr;
    logic [DATA_W-1:0] p_wdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: at the falling edge, check request stability and answer the bus.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (pend && rst) begin
            if (!(bus.mem_req === 1'b1 && bus.mem_we === p_we &&
                  bus.mem_addr === p_addr && bus.mem_wdata === p_wdata))
                stab_err++;
        end
        bus.mem_ack = 1'b0;
        if (bus.mem_req) begin
            bus.mem_rdata = mem[bus.mem_addr];
            if (cnt == wait_n) begin
                bus.mem_ack = 1'b1;
                cnt = 0;
                if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
                else if (bus.mem_addr == 5'd20) rd_cnt++;
            end else begin
                cnt++;
            end
        end else begin
            cnt = 0;
        end
        pend    = bus.mem_req && !bus.mem_ack && rst;
        p_we    = bus.mem_we;
        p_addr  = bus.mem_addr;
        p_wdata = bus.mem_wdata;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 32; i++) mem[i] = '0;
    endtask

    task automatic load_basic();
        clear_mem();
        mem[0]  = 8'h94;
        mem[1]  = 8'h95;
        mem[2]  = 8'h00;
        mem[3]  = 8'hB6;
        mem[4]  = 8'hC4;
        mem[20] = 8'd5;
        mem[21] = 8'd7;
    endtask

    task automatic hold_reset();
        rst = 1'b0;
        tick();
        tick();
    endtask

    task automatic release_reset();
        rst    = 1'b1;
        cyc    = 0;
        rd_cnt = 0;
    endtask

    task automatic run(input int max);
        while (!(halted || fault) && cyc < max) tick();
        check("stopped", {31'd0, halted | fault}, 1);
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        wait_n        = 0;
        cnt           = 0;
        stab_err      = 0;
        pend          = 1'b0;
        rst           = 1'b0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;

        // Reset state and the quiet cycle after release
        load_basic();
        hold_reset();
        check("rst_pc", pc, 0);
        check("rst_sp", sp, 0);
        check("rst_halted", halted, 0);
        check("rst_fault", fault, 0);
        check("rst_req", bus.mem_req, 0);
        release_reset();
        #1;
        check("post_rst_req", bus.mem_req, 0);

        // Basic program, zero-wait
        run(200);
        check("b0_mem22", mem[22], 12);
        check("b0_halted", halted, 1);
        check("b0_pc", pc, 4);
        check("b0_sp", sp, 0);
        check("b0_fault", fault, 0);
        check("b0_cycles", cyc, 16);

        // Basic program, three wait cycles per access
        load_basic();
        wait_n   = 3;
        stab_err = 0;
        hold_reset();
        release_reset();
        run(400);
        check("b3_mem22", mem[22], 12);
        check("b3_halted", halted, 1);
        check("b3_pc", pc, 4);
        check("b3_sp", sp, 0);
        check("b3_fault", fault, 0);
        check("b3_cycles", cyc, 40);
        check("b3_stable", stab_err, 0);

        // Nine pushes into an eight-entry stack
        clear_mem();
        for (int i = 0; i < 9; i++) mem[i] = 8'h94;
        mem[20] = 8'd9;
        wait_n  = 0;
        hold_reset();
        release_reset();
        run(200);
        check("ovf_fault", fault, 1);
        check("ovf_halted", halted, 0);
        check("ovf_sp", sp, 8);
        check("ovf_pc", pc, 9);
        check("ovf_reads", rd_cnt, 8);
        check("ovf_cycles", cyc, 27);

        // ADD with a single entry
        clear_mem();
        mem[0]  = 8'h94;
        mem[1]  = 8'h00;
        mem[20] = 8'd5;
        hold_reset();
        release_reset();
        run(200);
        check("und_fault", fault, 1);
        check("und_sp", sp, 1);
        check("und_cycles", cyc, 6);
        tick();
        tick();
        check("und_pc", pc, 2);
        check("und_req", bus.mem_req, 0);
        check("und_absorb", fault, 1);

        // JZ taken / not taken, SUB wrap, NOT, POP
        clear_mem();
        mem[0]  = 8'h97;
        mem[1]  = 8'hEA;
        mem[10] = 8'h98;
        mem[11] = 8'hE3;
        mem[12] = 8'h99;
        mem[13] = 8'h9A;
        mem[14] = 8'h20;
        mem[15] = 8'hBB;
        mem[16] = 8'h9B;
        mem[17] = 8'h60;
        mem[18] = 8'hBC;
        mem[19] = 8'hD3;
        mem[23] = 8'd0;
        mem[24] = 8'd3;
        mem[25] = 8'd3;
        mem[26] = 8'd5;
        hold_reset();
        release_reset();
        run_to(4);
        check("jz_pre_sp", sp, 1);
        run_to(7);
        check("jz_taken_pc", pc, 10);
        check("jz_taken_sp", sp, 0);
        run_to(13);
        check("jz_fall_pc", pc, 12);
        check("jz_fall_sp", sp, 0);
        run(200);
        check("sub_wrap", mem[27], 8'hFE);
        check("not_val", mem[28], 8'h01);
        check("alu_pc", pc, 19);
        check("alu_halted", halted, 1);
        check("alu_cycles", cyc, 37);

        // Reset during a fetch wait, stray ack one cycle later
        load_basic();
        wait_n = 3;
        hold_reset();
        release_reset();
        tick();
        tick();
        check("mid_wait_req", bus.mem_req, 1);
        rst = 1'b0;
        tick();
        release_reset();
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 8'hC0;
        tick();
        check("mid_pc", pc, 0);
        check("mid_sp", sp, 0);
        check("mid_still_fetch", bus.mem_req, 1);
        run(400);
        check("mid_mem22", mem[22], 12);
        check("mid_pc_end", pc, 4);
        check("mid_cycles", cyc, 40);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
